bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares the single port A of the element/recipe BRAM between two requesters: requester 0, the AXI register slave (CPU-side VRAM/recipe access), and requester 1, the hardware recipe-lookup engine.
- Arbitrates round-robin, with an optional bounded lock for atomic sequences.
- Registers the BRAM command and returns read data to the winning requester with a fixed, tagged latency.
- Sits between the AXI slave, the lookup engine and the BRAM instance inside the little_alchemy_controller IP.

Parameters:
ADDR_W, 10, BRAM word address width
DATA_W, 32, BRAM data width
RD_LAT, 2, BRAM read latency in cycles, counted from the address being on the port to douta being valid
LOCK_MAX, 16, maximum consecutive grants one locked requester may hold while the other is requesting

Ports:
axi_aclk  in  1  single clock
reset_ah  in  1  synchronous active-high reset
r0_req  in  1  requester 0 access request; held until r0_gnt
r0_we  in  1  requester 0 write (1) / read (0)
r0_lock  in  1  requester 0 wants to keep the port after this grant
r0_addr  in  ADDR_W  requester 0 word address
r0_wdata  in  DATA_W  requester 0 write data
r0_gnt  out  1  1-cycle pulse: request 0 accepted this cycle
r0_rvalid  out  1  1-cycle pulse: r0_rdata valid
r0_rdata  out  DATA_W  read data for requester 0
r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  (same directions, widths and meanings for requester 1)
bram_ena  out  1  BRAM port enable
bram_wea  out  1  BRAM write enable
bram_addra  out  ADDR_W  BRAM address
bram_dina  out  DATA_W  BRAM write data
bram_douta  in  DATA_W  BRAM read data

Behaviour:
- Reset values:
  - Control outputs: all gnt, rvalid, bram_ena and bram_wea are 0.
  - Data outputs: bram_addra, bram_dina, r0_rdata and r1_rdata are 0.
  - Arbitration state: last_winner=1, so requester 0 wins the first contention. lock_owner=none, lock_cnt=0.
  - Read pipeline: in-flight read pipeline cleared.
- Grant is combinational from the current req, lock and arbitration state, one grant per cycle:
  - Only one requester asserting req: it is granted.
  - Both requesting, no active lock: the requester that is not last_winner is granted.
  - Both requesting, active lock: the lock_owner is granted while lock_cnt < LOCK_MAX. Once lock_cnt reaches LOCK_MAX, the other requester is granted and the lock is cleared.
  - Neither requesting: no grant, and bram_ena=0 on the next cycle.
- Lock state update, on a grant to requester i:
  - last_winner<=i.
  - If ri_lock=1: lock_owner<=i, and lock_cnt increments (saturating) when the other requester is also requesting.
  - If ri_lock=0, or the other requester wins: lock_owner<=none and lock_cnt<=0.
  - A lock with no competing request never expires.
- Command register:
  - In the grant cycle T, the BRAM signals are latched and appear on the port at T+1.
  - A write completes at grant; the requester may deassert req or present a new request at T+1.
- Read return:
  - A read granted at T returns ri_rvalid=1 at T+1+RD_LAT, with ri_rdata=bram_douta sampled that cycle.
  - ri_rdata holds its value until the next rvalid for that requester.
  - Tracking uses a (1+RD_LAT)-deep shift register of {valid, requester id}. Back-to-back reads from either requester are fully pipelined, one per cycle, and return in grant order.
- Write/read hazard:
  - A read of an address written the previous cycle returns the BRAM's write-first/read-first result.
  - The arbiter adds no forwarding, and the bench must not depend on it.
- Address and data widths pass through unchanged; there is no arithmetic on addresses.
- Simultaneous events: both requesters asserting req in the same cycle as a lock expiry follows the priority order above; exactly one gnt pulses.
- Reset mid-operation:
  - In-flight reads are dropped: no rvalid is issued after reset.
  - The BRAM command is cleared the cycle after reset is asserted.
  - Arbitration state returns to its reset values.

Test Plan:
- Single read: preload addr 0x005=0xDEADBEEF; r0 reads 0x005 at T -> r0_gnt at T, bram_addra=0x005 at T+1, r0_rvalid with 0xDEADBEEF at T+3 (RD_LAT=2), r1_rvalid stays 0.
- Contention round-robin, after reset: r0 and r1 hold reads for 4 cycles -> grants alternate r0,r1,r0,r1; each rvalid returns the correct data to the correct requester in grant order.
- Pipelined writes then reads: r1 writes 0x010..0x013 with values 1..4 on consecutive cycles, then reads them back -> 4 gnt pulses for the writes and 4 rvalid pulses with data 1..4 on consecutive cycles.
- Lock limit: r1 holds lock=1 and reads continuously while r0 requests from cycle 0 -> r1 gets 16 consecutive grants, r0 is granted on the 17th, then round-robin resumes.
- Idle and lock without competition: r0 holds lock with r1 idle for 40 grants -> no expiry, bram_ena=1 each cycle; with no requests, bram_ena=0 and bram_wea=0.
- Reset mid-read: r0 read granted at T, reset_ah pulsed at T+1 -> no r0_rvalid at T+3; all outputs 0 at T+2; next contention grants r0 first.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing BRAM port A between the AXI slave (r0) and the
// recipe-lookup engine (r1), with a bounded lock and tagged read return.

module bram_port_ret #(
  parameter int DATA_W = 32
) (
  input  logic              axi_aclk,
  input  logic              reset_ah,
  input  logic              hit,
  input  logic [DATA_W-1:0] bram_douta,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge axi_aclk) begin
    if (reset_ah)  rdata_q <= '0;
    else if (hit)  rdata_q <= bram_douta;
  end

  // douta is only valid in the return cycle, so pass it through then and hold it after
  assign rvalid = hit;
  assign rdata  = hit ? bram_douta : rdata_q;
endmodule

module bram_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 2,
  parameter int LOCK_MAX = 16
) (
  input  logic              axi_aclk,
  input  logic              reset_ah,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  input  logic [DATA_W-1:0] bram_douta
);
  localparam int NR     = 2;
  localparam int STAGES = RD_LAT;
  localparam int CW     = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = LOCK_MAX[CW-1:0];

  typedef struct packed {
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  req_t [NR-1:0]     rq;
  tag_t [STAGES:0]   vld_pipe;
  tag_t              tag_nxt;
  logic [NR-1:0]     gnt;
  logic              win;
  logic              both;
  logic              last_winner;
  logic              lock_vld;
  logic              lock_owner;
  logic [CW-1:0]     lock_cnt;
  logic [NR-1:0]     hit;
  logic [NR-1:0]     rvalid;
  logic [NR-1:0][DATA_W-1:0] rdata;

  assign rq[0] = '{req: r0_req, we: r0_we, lock: r0_lock, addr: r0_addr, wdata: r0_wdata};
  assign rq[1] = '{req: r1_req, we: r1_we, lock: r1_lock, addr: r1_addr, wdata: r1_wdata};
  assign both  = rq[0].req & rq[1].req;

  always_comb begin
    gnt     = '0;
    win     = 1'b0;
    tag_nxt = '0;
    if (!reset_ah) begin
      unique case ({rq[1].req, rq[0].req})
        2'b01:   win = 1'b0;
        2'b10:   win = 1'b1;
        2'b11:   if (lock_vld) win = (lock_cnt < CNT_MAX) ? lock_owner : ~lock_owner;
                 else          win = ~last_winner;
        default: win = 1'b0;
      endcase
      gnt[win]    = rq[0].req | rq[1].req;
      tag_nxt.vld = (|gnt) & ~rq[win].we;
      tag_nxt.id  = win;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (reset_ah) begin
      last_winner <= 1'b1;
      lock_vld    <= 1'b0;
      lock_owner  <= 1'b0;
      lock_cnt    <= '0;
      bram_ena    <= 1'b0;
      bram_wea    <= 1'b0;
      bram_addra  <= '0;
      bram_dina   <= '0;
      vld_pipe    <= '0;
    end else begin
      bram_ena <= |gnt;
      bram_wea <= (|gnt) & rq[win].we;
      vld_pipe <= {vld_pipe[STAGES-1:0], tag_nxt};
      if (|gnt) begin
        bram_addra  <= rq[win].addr;
        bram_dina   <= rq[win].wdata;
        last_winner <= win;
        if (rq[win].lock) begin
          lock_vld   <= 1'b1;
          lock_owner <= win;
          // count only contested grants; an uncontested lock never expires
          if (lock_vld && lock_owner == win)
            lock_cnt <= (both && lock_cnt != CNT_MAX) ? lock_cnt + 1'b1 : lock_cnt;
          else
            lock_cnt <= CW'(both);
        end else begin
          lock_vld <= 1'b0;
          lock_cnt <= '0;
        end
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_ret
    assign hit[i] = vld_pipe[STAGES].vld && (vld_pipe[STAGES].id == 1'(i));
    bram_port_ret #(.DATA_W(DATA_W)) u_ret (
      .axi_aclk  (axi_aclk),
      .reset_ah  (reset_ah),
      .hit       (hit[i]),
      .bram_douta(bram_douta),
      .rvalid    (rvalid[i]),
      .rdata     (rdata[i])
    );
  end

  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];
  assign r0_rvalid = rvalid[0];
  assign r1_rvalid = rvalid[1];
  assign r0_rdata  = rdata[0];
  assign r1_rdata  = rdata[1];
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: behavioural BRAM, per-cycle reference model
// and directed scenarios with literal expectations.
module tb_bram_port_arbiter;
  localparam int LOCK_MAX = 16;

  logic        clk = 0;
  logic        reset_ah = 1;
  logic        r0_req = 0, r0_we = 0, r0_lock = 0;
  logic [9:0]  r0_addr = 0;
  logic [31:0] r0_wdata = 0;
  logic        r1_req = 0, r1_we = 0, r1_lock = 0;
  logic [9:0]  r1_addr = 0;
  logic [31:0] r1_wdata = 0;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        bram_ena, bram_wea;
  logic [9:0]  bram_addra;
  logic [31:0] bram_dina, bram_douta;

  bram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(2), .LOCK_MAX(LOCK_MAX)) dut (
    .axi_aclk(clk), .reset_ah(reset_ah),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
    .bram_dina(bram_dina), .bram_douta(bram_douta)
  );

  always #5 clk = ~clk;

  // BRAM with 2-cycle read latency, read-first
  logic [31:0] mem [1024];
  logic [31:0] p0, p1;
  always @(posedge clk) begin
    if (bram_ena) begin
      if (bram_wea) mem[bram_addra] <= bram_dina;
      p0 <= mem[bram_addra];
    end
    p1 <= p0;
  end
  assign bram_douta = p1;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // reference model
  typedef struct {int due; int id; logic [31:0] data;} ret_t;
  ret_t        ret_q[$];
  int          m_last = 1, m_owner = -1, m_cnt = 0, cyc = 0;
  logic        e_ena = 0, e_wea = 0;
  logic [9:0]  e_addr = 0;
  logic [31:0] e_din = 0;
  logic [31:0] e_rd0 = 0, e_rd1 = 0;
  logic [31:0] shadow [1024];
  int          glog[$];
  logic [31:0] rv0_log[$], rv1_log[$];
  bit          chk_en = 0;

  always @(negedge clk) begin
    int w;
    bit both, ev0, ev1, lk, we;
    logic [9:0]  ad;
    logic [31:0] wd, ed;
    ev0 = 0; ev1 = 0; ed = '0;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      ev0 = (ret_q[0].id == 0);
      ev1 = (ret_q[0].id == 1);
      ed  = ret_q[0].data;
      void'(ret_q.pop_front());
    end
    if (ev0) e_rd0 = ed;
    if (ev1) e_rd1 = ed;
    if (r0_rvalid) rv0_log.push_back(r0_rdata);
    if (r1_rvalid) rv1_log.push_back(r1_rdata);
    if (chk_en) begin
      chk("bram_ena", bram_ena, e_ena);
      chk("bram_wea", bram_wea, e_wea);
      if (e_ena) chk("bram_addra", bram_addra, e_addr);
      if (e_ena && e_wea) chk("bram_dina", bram_dina, e_din);
      chk("r0_rvalid", r0_rvalid, ev0);
      chk("r1_rvalid", r1_rvalid, ev1);
      chk("r0_rdata", r0_rdata, e_rd0);
      chk("r1_rdata", r1_rdata, e_rd1);
    end
    both = r0_req && r1_req;
    w = -1;
    if (!reset_ah) begin
      if (r0_req && !r1_req)      w = 0;
      else if (r1_req && !r0_req) w = 1;
      else if (both) begin
        if (m_owner >= 0) w = (m_cnt < LOCK_MAX) ? m_owner : 1 - m_owner;
        else              w = 1 - m_last;
      end
    end
    glog.push_back(w);
    if (chk_en) begin
      chk("r0_gnt", r0_gnt, w == 0);
      chk("r1_gnt", r1_gnt, w == 1);
    end
    if (reset_ah) begin
      m_last = 1; m_owner = -1; m_cnt = 0;
      e_ena = 0; e_wea = 0; e_rd0 = 0; e_rd1 = 0;
      ret_q.delete();
    end else begin
      e_ena = (w >= 0);
      e_wea = 0;
      if (w >= 0) begin
        lk = (w == 0) ? r0_lock : r1_lock;
        we = (w == 0) ? r0_we : r1_we;
        ad = (w == 0) ? r0_addr : r1_addr;
        wd = (w == 0) ? r0_wdata : r1_wdata;
        e_wea = we; e_addr = ad; e_din = wd; m_last = w;
        if (lk) begin
          if (m_owner != w) m_cnt = both ? 1 : 0;
          else if (both && m_cnt < LOCK_MAX) m_cnt++;
          m_owner = w;
        end else begin
          m_owner = -1; m_cnt = 0;
        end
        if (we) shadow[ad] = wd;
        else    ret_q.push_back('{cyc + 3, w, shadow[ad]});
      end
    end
    cyc++;
  end

  task automatic set(input logic q0, w0, l0, input logic [9:0] a0, input logic [31:0] d0,
                     input logic q1, w1, l1, input logic [9:0] a1, input logic [31:0] d1);
    r0_req = q0; r0_we = w0; r0_lock = l0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_lock = l1; r1_addr = a1; r1_wdata = d1;
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    set(0,0,0,0,0, 0,0,0,0,0);
    repeat (n) step();
  endtask
  function automatic int cnt_in(input int s, input int n, input int v);
    int c = 0;
    for (int k = s; k < s + n; k++) if (glog[k] == v) c++;
    return c;
  endfunction

  initial begin
    int s, n0, n1;
    step(); chk_en = 1;
    #2;
    chk("rst_ena", bram_ena, 0); chk("rst_addra", bram_addra, 0);
    chk("rst_dina", bram_dina, 0); chk("rst_rdata0", r0_rdata, 0);
    step(); reset_ah = 0;

    // preload through r0 writes
    set(1,1,0,10'h005,32'hDEADBEEF, 0,0,0,0,0); step();
    set(1,1,0,10'h020,32'hA0A00020, 0,0,0,0,0); step();
    set(1,1,0,10'h021,32'h21210021, 0,0,0,0,0); step();
    idle(2);

    // single read
    set(1,0,0,10'h005,0, 0,0,0,0,0); #2;
    chk("sr_gnt", r0_gnt, 1);
    step(); set(0,0,0,0,0, 0,0,0,0,0); #2;
    chk("sr_addr", bram_addra, 10'h005); chk("sr_ena", bram_ena, 1);
    step(); step(); #2;
    chk("sr_rvalid0", r0_rvalid, 1); chk("sr_rdata0", r0_rdata, 32'hDEADBEEF);
    chk("sr_rvalid1", r1_rvalid, 0);
    idle(2);

    // reset mid-read; r0 just won so without reset r1 would win next contention
    set(1,0,0,10'h005,0, 0,0,0,0,0); step();
    set(0,0,0,0,0, 0,0,0,0,0); reset_ah = 1; step();
    reset_ah = 0; #2;
    chk("mr_out0", {bram_ena, bram_wea, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid}, 0);
    chk("mr_addr0", bram_addra, 0); chk("mr_dina0", bram_dina, 0);
    chk("mr_rdata0", r0_rdata, 0);
    step(); #2;
    chk("mr_norvalid", r0_rvalid, 0);

    // contention round-robin
    n0 = rv0_log.size(); n1 = rv1_log.size(); s = glog.size();
    set(1,0,0,10'h020,0, 1,0,0,10'h021,0);
    repeat (4) step();
    idle(4);
    chk("rr_seq", {glog[s], glog[s+1], glog[s+2], glog[s+3]}, {32'd0, 32'd1, 32'd0, 32'd1});
    chk("rr_n0", rv0_log.size() - n0, 2); chk("rr_n1", rv1_log.size() - n1, 2);
    chk("rr_d0", rv0_log[n0+1], 32'hA0A00020); chk("rr_d1", rv1_log[n1+1], 32'h21210021);

    // pipelined writes then reads on r1
    n1 = rv1_log.size(); s = glog.size();
    for (int k = 0; k < 4; k++) begin set(0,0,0,0,0, 1,1,0,10'h010 + 10'(k),32'(k+1)); step(); end
    for (int k = 0; k < 4; k++) begin set(0,0,0,0,0, 1,0,0,10'h010 + 10'(k),0); step(); end
    idle(4);
    chk("pw_grants", cnt_in(s, 8, 1), 8);
    chk("pw_nrv", rv1_log.size() - n1, 4);
    chk("pw_data", {rv1_log[n1], rv1_log[n1+1], rv1_log[n1+2], rv1_log[n1+3]},
        {32'd1, 32'd2, 32'd3, 32'd4});

    // lock limit: r0 wins once so r1 takes the first contested grant
    set(1,0,0,10'h020,0, 0,0,0,0,0); step();
    s = glog.size();
    set(1,0,0,10'h020,0, 1,0,1,10'h005,0); repeat (17) step();
    set(1,0,0,10'h020,0, 1,0,0,10'h005,0); repeat (4) step();
    idle(4);
    chk("lk_r1run", cnt_in(s, 16, 1), 16);
    chk("lk_17th", glog[s+16], 0);
    chk("lk_rr", {glog[s+17], glog[s+18], glog[s+19], glog[s+20]}, {32'd1, 32'd0, 32'd1, 32'd0});

    // uncontested lock never expires
    s = glog.size();
    set(1,0,1,10'h021,0, 0,0,0,0,0); repeat (40) step();
    chk("ul_grants", cnt_in(s, 40, 0), 40);
    chk("ul_model", {m_owner, m_cnt}, {32'd0, 32'd0});
    idle(3); #2;
    chk("idle_ena", {bram_ena, bram_wea}, 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
